obstacle_collide: RTL and testbench

OBSTACLE_COLLIDE -- requirements
Module: obstacle_collide

---
 rtl/obstacle_pkg.sv | 19 +
 rtl/box_overlap.sv | 28 ++
 rtl/obstacle_collide.sv | 195 +++++++++++++++++++
 tb/tb_obstacle_collide.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_pkg.sv
// Shared definitions for the obstacle collision scanner: coordinate widths
// and the scan FSM state encoding.
package obstacle_pkg;

  // Screen coordinates, sizes and offsets are 10-bit pixel values.
  localparam int COORD_W = 10;

  // Box edges need one more bit: a centre plus a half-size, or a corner plus a
  // width, can reach past 1023 without wrapping.
  localparam int EXT_W   = COORD_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/box_overlap.sv
// Combinational overlap test between two axis-aligned boxes given as inclusive
// edge coordinates. Box B may be flagged empty (zero width or height), in which
// case it never overlaps anything.
module box_overlap
  import obstacle_pkg::*;
(
  input  logic [EXT_W-1:0] i_a_left,
  input  logic [EXT_W-1:0] i_a_right,
  input  logic [EXT_W-1:0] i_a_top,
  input  logic [EXT_W-1:0] i_a_bottom,
  input  logic [EXT_W-1:0] i_b_left,
  input  logic [EXT_W-1:0] i_b_right,
  input  logic [EXT_W-1:0] i_b_top,
  input  logic [EXT_W-1:0] i_b_bottom,
  input  logic             i_b_empty,
  output logic             o_hit
);

  logic w_x_overlap;
  logic w_y_overlap;

  // Inclusive comparisons: boxes that share only an edge pixel still overlap.
  assign w_x_overlap = (i_a_left <= i_b_right)  && (i_b_left <= i_a_right);
  assign w_y_overlap = (i_a_top  <= i_b_bottom) && (i_b_top  <= i_a_bottom);

  assign o_hit = !i_b_empty && w_x_overlap && w_y_overlap;

endmodule

// File: rtl/obstacle_collide.sv
// Per-frame collision scanner. On frame_start the player box and all obstacle
// boxes are snapshotted, then one obstacle per cycle is tested against the
// player through a single shared box_overlap instance. The result vector is
// published together with a one-cycle hit_valid pulse and held until the next
// scan completes.
module obstacle_collide
  import obstacle_pkg::*;
#(
  parameter int N_OBS = 4
)(
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     frame_start,
  input  logic [COORD_W-1:0]       BallX,
  input  logic [COORD_W-1:0]       BallY,
  input  logic [COORD_W-1:0]       BallS,
  input  logic [COORD_W*N_OBS-1:0] ObsX_all,
  input  logic [COORD_W*N_OBS-1:0] ObsY_all,
  input  logic [COORD_W*N_OBS-1:0] ObsW_all,
  input  logic [COORD_W*N_OBS-1:0] ObsH_all,
  output logic [N_OBS-1:0]         hit_vec,
  output logic                     any_hit,
  output logic                     hit_valid,
  output logic                     busy,
  output logic                     overrun
);

  localparam int                IDX_W    = (N_OBS > 1) ? $clog2(N_OBS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_OBS - 1);

  // Control state
  state_t             r_state;
  state_t             w_next_state;
  logic [IDX_W-1:0]   r_idx;
  logic [N_OBS-1:0]   r_scratch;
  logic [N_OBS-1:0]   r_hit_vec;
  logic               r_overrun;

  // Snapshot of the inputs taken in LATCH
  logic [COORD_W-1:0] r_ball_x;
  logic [COORD_W-1:0] r_ball_y;
  logic [COORD_W-1:0] r_ball_s;
  logic [COORD_W-1:0] r_obs_x [N_OBS];
  logic [COORD_W-1:0] r_obs_y [N_OBS];
  logic [COORD_W-1:0] r_obs_w [N_OBS];
  logic [COORD_W-1:0] r_obs_h [N_OBS];

  // Player box edges
  logic signed [EXT_W-1:0] w_pl_left_s;
  logic signed [EXT_W-1:0] w_pl_top_s;
  logic [EXT_W-1:0]        w_pl_left;
  logic [EXT_W-1:0]        w_pl_right;
  logic [EXT_W-1:0]        w_pl_top;
  logic [EXT_W-1:0]        w_pl_bottom;

  // Currently selected obstacle and its box edges
  logic [COORD_W-1:0]      w_obs_x;
  logic [COORD_W-1:0]      w_obs_y;
  logic [COORD_W-1:0]      w_obs_w;
  logic [COORD_W-1:0]      w_obs_h;
  logic [EXT_W-1:0]        w_ob_left;
  logic [EXT_W-1:0]        w_ob_right;
  logic [EXT_W-1:0]        w_ob_top;
  logic [EXT_W-1:0]        w_ob_bottom;
  logic                    w_ob_empty;
  logic                    w_hit;

  // ---------------------------------------------------------------------------
  // Player box: centre minus/plus half-size. The low edges can go negative
  // near the screen origin and are clamped to pixel 0; the high edges fit in
  // 11 bits unsigned without wrapping.
  // ---------------------------------------------------------------------------
  assign w_pl_left_s = $signed({1'b0, r_ball_x}) - $signed({1'b0, r_ball_s});
  assign w_pl_top_s  = $signed({1'b0, r_ball_y}) - $signed({1'b0, r_ball_s});
  assign w_pl_left   = w_pl_left_s[EXT_W-1] ? '0 : $unsigned(w_pl_left_s);
  assign w_pl_top    = w_pl_top_s[EXT_W-1]  ? '0 : $unsigned(w_pl_top_s);
  assign w_pl_right  = {1'b0, r_ball_x} + {1'b0, r_ball_s};
  assign w_pl_bottom = {1'b0, r_ball_y} + {1'b0, r_ball_s};

  // ---------------------------------------------------------------------------
  // Obstacle box for the current scan index. A zero width/height would make
  // the right/bottom edge land one pixel before the corner, so such boxes are
  // flagged empty instead of relying on the edge arithmetic.
  // ---------------------------------------------------------------------------
  assign w_obs_x     = r_obs_x[r_idx];
  assign w_obs_y     = r_obs_y[r_idx];
  assign w_obs_w     = r_obs_w[r_idx];
  assign w_obs_h     = r_obs_h[r_idx];
  assign w_ob_left   = {1'b0, w_obs_x};
  assign w_ob_top    = {1'b0, w_obs_y};
  assign w_ob_right  = {1'b0, w_obs_x} + {1'b0, w_obs_w} - EXT_W'(1);
  assign w_ob_bottom = {1'b0, w_obs_y} + {1'b0, w_obs_h} - EXT_W'(1);
  assign w_ob_empty  = (w_obs_w == '0) || (w_obs_h == '0);

  box_overlap u_box_overlap (
    .i_a_left   (w_pl_left),
    .i_a_right  (w_pl_right),
    .i_a_top    (w_pl_top),
    .i_a_bottom (w_pl_bottom),
    .i_b_left   (w_ob_left),
    .i_b_right  (w_ob_right),
    .i_b_top    (w_ob_top),
    .i_b_bottom (w_ob_bottom),
    .i_b_empty  (w_ob_empty),
    .o_hit      (w_hit)
  );

  // FSM state register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic: one LATCH cycle, N_OBS CHECK cycles, one DONE cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (frame_start) w_next_state = ST_LATCH;
      ST_LATCH: w_next_state = ST_CHECK;
      ST_CHECK: if (r_idx == LAST_IDX) w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // FSM outputs: during DONE the fresh scratch result is presented directly so
  // hit_vec is already valid in the hit_valid cycle; afterwards the held copy.
  always_comb begin
    busy      = (r_state != ST_IDLE);
    hit_valid = (r_state == ST_DONE);
    hit_vec   = (r_state == ST_DONE) ? r_scratch : r_hit_vec;
    any_hit   = |hit_vec;
    overrun   = r_overrun;
  end

  // Scan index and scratch result vector, one obstacle bit written per CHECK cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_idx     <= '0;
      r_scratch <= '0;
    end else begin
      case (r_state)
        ST_LATCH: begin
          r_idx     <= '0;
          r_scratch <= '0;
        end
        ST_CHECK: begin
          r_scratch[r_idx] <= w_hit;
          r_idx            <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
        end
        default: begin
          r_idx <= '0;
        end
      endcase
    end
  end

  // Held result: captured at the end of DONE and kept until the next DONE.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_hit_vec <= '0;
    end else if (r_state == ST_DONE) begin
      r_hit_vec <= r_scratch;
    end
  end

  // Overrun flag: set by a frame_start that arrives while a scan is running,
  // cleared by the next frame_start that is actually accepted.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_overrun <= 1'b0;
    end else if (frame_start) begin
      r_overrun <= (r_state != ST_IDLE);
    end
  end

  // Input snapshot taken in LATCH; pure data, so no reset is needed.
  always_ff @(posedge Clk) begin
    if (r_state == ST_LATCH) begin
      r_ball_x <= BallX;
      r_ball_y <= BallY;
      r_ball_s <= BallS;
      for (int i = 0; i < N_OBS; i++) begin
        r_obs_x[i] <= ObsX_all[i*COORD_W +: COORD_W];
        r_obs_y[i] <= ObsY_all[i*COORD_W +: COORD_W];
        r_obs_w[i] <= ObsW_all[i*COORD_W +: COORD_W];
        r_obs_h[i] <= ObsH_all[i*COORD_W +: COORD_W];
      end
    end
  end

endmodule

// File: tb/tb_obstacle_collide.sv
// Directed bench for obstacle_collide with N_OBS=4. Obstacle set:
//   obs0 (100,127) 50x40, obs1 (0,0) 10x10, obs2 (0,0) 0x10 (empty),
//   obs3 (500,500) 20x20.
module tb_obstacle_collide;

  localparam int N = 4;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          frame_start;
  logic [9:0]    BallX, BallY, BallS;
  logic [10*N-1:0] ObsX_all, ObsY_all, ObsW_all, ObsH_all;
  logic [N-1:0]  hit_vec;
  logic          any_hit, hit_valid, busy, overrun;

  int checks   = 0;
  int failures = 0;

  obstacle_collide #(.N_OBS(N)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .BallX       (BallX),
    .BallY       (BallY),
    .BallS       (BallS),
    .ObsX_all    (ObsX_all),
    .ObsY_all    (ObsY_all),
    .ObsW_all    (ObsW_all),
    .ObsH_all    (ObsH_all),
    .hit_vec     (hit_vec),
    .any_hit     (any_hit),
    .hit_valid   (hit_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string      name;
    logic [9:0] bx;
    logic [9:0] by;
    logic [9:0] bs;
    logic [3:0] exp_hv;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Pulses frame_start in the current cycle (cycle 0) and waits, bounded, for
  // hit_valid. Optionally rewrites BallX once the scan has reached chg_cycle.
  task automatic do_scan(input int chg_cycle, input logic [9:0] chg_x,
                         output logic [3:0] hv, output logic ah, output int lat);
    frame_start = 1'b1;
    @(posedge Clk); #1;
    frame_start = 1'b0;
    lat = 1;
    while (hit_valid !== 1'b1 && lat < 20) begin
      if (lat == chg_cycle) BallX = chg_x;
      check("busy_during_scan", {31'd0, busy}, 32'd1);
      @(posedge Clk); #1;
      lat++;
    end
    hv = hit_vec;
    ah = any_hit;
  endtask

  task automatic scan_and_check(input string name, input int chg_cycle, input logic [9:0] chg_x,
                                input logic [3:0] exp_hv);
    logic [3:0] hv;
    logic       ah;
    int         lat;
    do_scan(chg_cycle, chg_x, hv, ah, lat);
    check({name, "_latency"}, lat, 32'd6);
    check({name, "_hit_vec"}, {28'd0, hv}, {28'd0, exp_hv});
    check({name, "_any_hit"}, {31'd0, ah}, {31'd0, |exp_hv});
    @(posedge Clk); #1;
    check({name, "_valid_one_cycle"}, {31'd0, hit_valid}, 32'd0);
    check({name, "_idle_after"}, {31'd0, busy}, 32'd0);
    check({name, "_hold"}, {28'd0, hit_vec}, {28'd0, exp_hv});
  endtask

  initial begin
    int pulses;
    int pulse_cycle;
    int busy_seen;

    vecs[0] = '{"inside_obs0",      10'd150,  10'd140,  10'd4,    4'b0001};
    vecs[1] = '{"miss_right_obs0",  10'd154,  10'd140,  10'd4,    4'b0000};
    vecs[2] = '{"edge_touch_obs0",  10'd153,  10'd140,  10'd4,    4'b0001};
    vecs[3] = '{"corner_clamp",     10'd2,    10'd2,    10'd4,    4'b0010};
    vecs[4] = '{"top_edge_obs3",    10'd510,  10'd490,  10'd10,   4'b1000};
    vecs[5] = '{"point_origin",     10'd0,    10'd0,    10'd0,    4'b0010};
    vecs[6] = '{"huge_ball",        10'd1023, 10'd1023, 10'd1023, 4'b1011};
    vecs[7] = '{"miss_right_obs3",  10'd530,  10'd510,  10'd10,   4'b0000};
    vecs[8] = '{"miss_above_obs3",  10'd510,  10'd489,  10'd10,   4'b0000};

    ObsX_all = {10'd500, 10'd0, 10'd0, 10'd100};
    ObsY_all = {10'd500, 10'd0, 10'd0, 10'd127};
    ObsW_all = {10'd20,  10'd0, 10'd10, 10'd50};
    ObsH_all = {10'd20,  10'd10, 10'd10, 10'd40};
    BallX = 10'd150; BallY = 10'd140; BallS = 10'd4;
    frame_start = 1'b0;
    Reset_n = 1'b0;

    repeat (2) @(posedge Clk);
    #1;
    check("reset_hit_vec",   {28'd0, hit_vec},   32'd0);
    check("reset_any_hit",   {31'd0, any_hit},   32'd0);
    check("reset_hit_valid", {31'd0, hit_valid}, 32'd0);
    check("reset_busy",      {31'd0, busy},      32'd0);
    check("reset_overrun",   {31'd0, overrun},   32'd0);
    Reset_n = 1'b1;
    @(posedge Clk); #1;

    for (int i = 0; i < 9; i++) begin
      BallX = vecs[i].bx; BallY = vecs[i].by; BallS = vecs[i].bs;
      scan_and_check(vecs[i].name, 0, 10'd0, vecs[i].exp_hv);
    end

    // Overrun: second frame_start in cycle 3 of a scan.
    BallX = 10'd150; BallY = 10'd140; BallS = 10'd4;
    frame_start = 1'b1;
    @(posedge Clk); #1;
    frame_start = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    frame_start = 1'b1;
    @(posedge Clk); #1;
    frame_start = 1'b0;
    check("overrun_set", {31'd0, overrun}, 32'd1);
    pulses = 0; pulse_cycle = 0;
    for (int c = 4; c <= 12; c++) begin
      if (hit_valid === 1'b1) begin
        pulses++;
        pulse_cycle = c;
      end
      @(posedge Clk); #1;
    end
    check("overrun_single_pulse", pulses, 32'd1);
    check("overrun_pulse_cycle", pulse_cycle, 32'd6);
    check("overrun_sticky", {31'd0, overrun}, 32'd1);
    check("overrun_scan_result", {28'd0, hit_vec}, 32'd1);
    frame_start = 1'b1;
    @(posedge Clk); #1;
    frame_start = 1'b0;
    check("overrun_cleared", {31'd0, overrun}, 32'd0);
    repeat (8) @(posedge Clk);
    #1;

    // Reset in cycle 3 of a scan, with overrun set and a nonzero held result.
    BallX = 10'd2; BallY = 10'd2; BallS = 10'd4;
    frame_start = 1'b1;
    @(posedge Clk); #1;
    frame_start = 1'b0;
    @(posedge Clk); #1;
    frame_start = 1'b1;
    @(posedge Clk); #1;
    frame_start = 1'b0;
    check("pre_reset_overrun", {31'd0, overrun}, 32'd1);
    check("pre_reset_hit_vec", {28'd0, hit_vec}, 32'd1);
    #2;
    Reset_n = 1'b0;
    #1;
    check("midscan_reset_hit_vec",   {28'd0, hit_vec},   32'd0);
    check("midscan_reset_any_hit",   {31'd0, any_hit},   32'd0);
    check("midscan_reset_hit_valid", {31'd0, hit_valid}, 32'd0);
    check("midscan_reset_busy",      {31'd0, busy},      32'd0);
    check("midscan_reset_overrun",   {31'd0, overrun},   32'd0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    pulses = 0; busy_seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (hit_valid === 1'b1) pulses++;
      if (busy === 1'b1) busy_seen++;
      @(posedge Clk); #1;
    end
    check("post_reset_no_pulse", pulses, 32'd0);
    check("post_reset_no_busy", busy_seen, 32'd0);
    scan_and_check("post_reset_scan", 0, 10'd0, 4'b0010);

    // Input changes after LATCH must not affect the running scan.
    BallX = 10'd154; BallY = 10'd140; BallS = 10'd4;
    scan_and_check("latched_miss", 2, 10'd150, 4'b0000);
    BallX = 10'd150;
    scan_and_check("latched_hit", 3, 10'd154, 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
